// File: rtl/fifo_write_arbiter_pkg.sv
// ============================================================================
//  Module  : fifo_write_arbiter_pkg
//  Brief   : Shared state encoding and helper function for the FIFO write arbiter
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package fifo_write_arbiter_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Same ceiling-log2 used by the FIFO; evaluated at elaboration only.
    function automatic int clog2(input int value);
        int r;
        for (r = 0; (1 << r) < value; r++) begin
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_write_arbiter_rr_pick.sv
// ============================================================================
//  Module  : rr_pick
//  Brief   : Combinational round-robin picker (double-width mask technique)
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   gnt,
    output logic               any
);

    localparam int c_DBL_W = 2 * NUM_REQ;

    logic [c_DBL_W-1:0] w_dbl;
    logic [c_DBL_W-1:0] w_mask;
    logic [c_DBL_W-1:0] w_masked;

    // The upper copy of req guarantees that the wrap-around candidates sit
    // above ptr, so the lowest surviving bit is always the round-robin winner.
    always_comb begin
        w_dbl    = {req, req};
        w_mask   = ~((c_DBL_W'(1) << ptr) - c_DBL_W'(1));
        w_masked = w_dbl & w_mask;
        gnt      = '0;
        for (int i = c_DBL_W - 1; i >= 0; i--) begin
            if (w_masked[i]) begin
                gnt = SRC_W'(i % NUM_REQ);
            end
        end
        any = |req;
    end

endmodule

`default_nettype wire

// File: rtl/fifo_write_arbiter.sv
// ============================================================================
//  Module  : fifo_write_arbiter
//  Brief   : Round-robin burst arbiter feeding the single cdcfifo write port
//  Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_write_arbiter
    import fifo_write_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 8,
    parameter int MAX_BURST  = 16,
    parameter int SRC_W      = clog2(NUM_REQ)
) (
    input  logic                          wrclk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            reqValid,
    input  logic [NUM_REQ-1:0]            reqLast,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] reqData,
    output logic [NUM_REQ-1:0]            reqReady,
    output logic                          writeValid,
    output logic [FIFO_WIDTH-1:0]         writeData,
    output logic [SRC_W-1:0]              writeSrc,
    input  logic                          writeReady,
    output logic                          busy
);

    localparam int                 c_CNT_W      = (MAX_BURST > 1) ? clog2(MAX_BURST) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT  = c_CNT_W'(MAX_BURST - 1);
    localparam logic [SRC_W-1:0]   c_LAST_OWNER = SRC_W'(NUM_REQ - 1);

    logic [0:0]            r_state;
    logic [SRC_W-1:0]      r_owner;
    logic [SRC_W-1:0]      r_rr_ptr;
    logic [c_CNT_W-1:0]    r_beat_cnt;
    logic                  r_write_valid;
    logic [FIFO_WIDTH-1:0] r_write_data;
    logic [SRC_W-1:0]      r_write_src;

    logic [0:0]            w_state_nxt;
    logic [SRC_W-1:0]      w_owner_nxt;
    logic [SRC_W-1:0]      w_rr_ptr_nxt;
    logic [c_CNT_W-1:0]    w_beat_cnt_nxt;
    logic                  w_busy;
    logic                  w_load_ok;
    logic                  w_xfer;
    logic [SRC_W-1:0]      w_pick_gnt;
    logic                  w_pick_any;
    logic [FIFO_WIDTH-1:0] w_owner_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_pick (
        .req (reqValid),
        .ptr (r_rr_ptr),
        .gnt (w_pick_gnt),
        .any (w_pick_any)
    );

    assign w_busy       = (r_state == ST_BURST);
    assign w_load_ok    = !r_write_valid || writeReady;
    assign w_xfer       = w_busy && w_load_ok && reqValid[r_owner];
    assign w_owner_data = reqData[r_owner*FIFO_WIDTH +: FIFO_WIDTH];

    always_comb begin
        reqReady = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_busy && w_load_ok && (r_owner == SRC_W'(i))) begin
                reqReady[i] = 1'b1;
            end
        end
    end

    // A grant ends on the packet's last beat or when the burst cap is hit;
    // a stalled owner keeps the grant indefinitely.
    always_comb begin
        w_state_nxt    = r_state;
        w_owner_nxt    = r_owner;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_beat_cnt_nxt = r_beat_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt    = ST_BURST;
                    w_owner_nxt    = w_pick_gnt;
                    w_beat_cnt_nxt = '0;
                end
            end
            ST_BURST: begin
                if (w_xfer) begin
                    if (reqLast[r_owner] || (r_beat_cnt == c_LAST_BEAT)) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = (r_owner == c_LAST_OWNER) ? '0 : r_owner + 1'b1;
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge wrclk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_owner       <= '0;
            r_rr_ptr      <= '0;
            r_beat_cnt    <= '0;
            r_write_valid <= 1'b0;
            r_write_data  <= '0;
            r_write_src   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_beat_cnt <= w_beat_cnt_nxt;
            if (w_load_ok) begin
                r_write_valid <= w_xfer;
                if (w_xfer) begin
                    r_write_data <= w_owner_data;
                    r_write_src  <= r_owner;
                end
            end
        end
    end

    assign writeValid = r_write_valid;
    assign writeData  = r_write_data;
    assign writeSrc   = r_write_src;
    assign busy       = w_busy;

endmodule

`default_nettype wire

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter sharing the single write port of cdcfifo among NUM_REQ requesters in the wrclk domain.
- Grants one requester at a time for a packet (until reqLast) or up to MAX_BURST beats, whichever comes first.
- Registers the selected beat into a one-entry output stage that drives writeValid/writeData into the FIFO.
- Tags each beat with the source index for debug and trace.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- FIFO_WIDTH, 8, data width per beat; matches the cdcfifo width.
- MAX_BURST, 16, maximum beats per grant before forced rotation (1..256).
- SRC_W, $clog2(NUM_REQ), width of the source index.

Ports:
- wrclk  in  1  write-domain clock; sole clock.
- rst  in  1  synchronous, active-high reset.
- reqValid  in  NUM_REQ  per-requester beat valid.
- reqLast  in  NUM_REQ  per-requester last beat of packet.
- reqData  in  NUM_REQ*FIFO_WIDTH  per-requester data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
- reqReady  out  NUM_REQ  per-requester beat accepted.
- writeValid  out  1  to cdcfifo writeValid.
- writeData  out  FIFO_WIDTH  to cdcfifo writeData.
- writeSrc  out  SRC_W  source index of the beat in writeData.
- writeReady  in  1  from cdcfifo writeReady.
- busy  out  1  high in BURST state.

Behaviour:
- Single clock. Reset is synchronous and active-high: on a wrclk edge with rst=1, all state clears.
- Reset values: writeValid=0, writeData=0, writeSrc=0, reqReady=0, busy=0, state=IDLE, owner=0, rrPtr=0, beatCnt=0.
- Output stage: loadOk = !writeValid || writeReady.
  - On loadOk with a requester transfer: writeValid<=1, writeData<=reqData[owner], writeSrc<=owner.
  - On loadOk with no transfer: writeValid<=0; writeData and writeSrc hold.
  - A beat leaves the output stage when writeValid && writeReady.
- reqReady[i] = (state==BURST) && (owner==i) && loadOk. This is combinational from registered state and writeReady. All other bits are 0.
- A requester transfer is reqValid[owner] && reqReady[owner].
- IDLE state:
  - If any reqValid is set, select the first set bit scanning rrPtr, rrPtr+1, ... NUM_REQ-1, 0, ... (wrapping).
  - Set owner<=selected, beatCnt<=0, go to BURST.
  - No data moves in the IDLE cycle, so arbitration latency is 1 cycle.
  - If no reqValid is set, stay in IDLE.
- BURST state, on each requester transfer:
  - If reqLast[owner] is set, or beatCnt==MAX_BURST-1: go to IDLE and set rrPtr <= (owner==NUM_REQ-1) ? 0 : owner+1.
  - Otherwise beatCnt<=beatCnt+1.
- BURST, no transfer (valid low or FIFO back-pressure): hold owner and beatCnt.
  - Protocol rule: a requester must not drop reqValid mid-packet. If it does, the grant is held; no timeout.
- MAX_BURST truncation only forces rotation. Remaining beats of a truncated packet are re-arbitrated later. reqLast is not generated by this block.
- Throughput: 1 beat/cycle while writeReady=1. There is 1 idle cycle per grant change.
- Latency: 1 cycle from a requester transfer to writeValid.
- Back-pressure: when writeReady=0 and writeValid=1, the output stage holds data stable and reqReady is all zero.
- Fairness: with all requesters continuously valid and packets ≤MAX_BURST, grant order is 0,1,...,NUM_REQ-1,0,...
- Reset mid-burst: the beat in the output stage is discarded, the grant is dropped, and rrPtr returns to 0.
- Reset with writeValid=1: writeValid drops the next cycle and no handshake completes.
- busy = (state==BURST).

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=1'b0, ST_BURST=1'b1;
  - the clog2 function already used by the FIFO.
- Sub-module rr_pick: combinational round-robin priority picker.
  - Inputs: req[NUM_REQ], ptr[SRC_W].
  - Outputs: gnt index and any.
  - Implemented with the double-width mask/rotate technique.
- FSM, beat counter and output register live in fifo_write_arbiter.

Test Plan:
- Reset: assert rst 3 cycles with reqValid=4'b1111 -> writeValid=0, reqReady=0, busy=0 during and the cycle after reset.
- Single requester: req 2 sends a 3-beat packet 0x11,0x22,0x33 (reqLast on 0x33), writeReady=1.
  - busy the cycle after reqValid.
  - writeData 0x11,0x22,0x33 on consecutive cycles with writeSrc=2.
  - Then IDLE and rrPtr=3.
- Round-robin: all 4 requesters valid with 1-beat packets, writeReady=1 -> writeSrc sequence 0,1,2,3,0,1, with one idle cycle between grants.
- MAX_BURST=4: req 0 sends a 6-beat packet while req 1 is waiting.
  - 4 beats from src 0, then 1 packet from src 1, then the remaining 2 beats from src 0.
- Back-pressure: writeReady=0 for 5 cycles mid-packet.
  - writeData and writeValid stay stable; reqReady=0.
  - When writeReady returns, no beat is lost or duplicated; scoreboard order matches.
- Reset mid-burst: rst asserted after beat 2 of 5 from req 3.
  - writeValid=0 next cycle.
  - After release with req 1 and req 3 both valid, the first grant goes to req 1 (rrPtr=0 scan reaches req 1 first).
